// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch port, the debug/loader port, the halt control
// and the single-ported instruction memory.
interface imem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              halt;
    logic              halted;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output halted, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  halted, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of the instruction memory: fetch has priority,
// debug is guaranteed service after MAX_WAIT refused cycles.
//   state  | meaning
//   RUN    | fetch and debug both eligible, starve counter active
//   HALTED | fetch blocked, debug granted whenever it requests
module imem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve;
    logic [CNT_W-1:0]  starve_nxt;
    logic              force_dbg;
    logic              f_gnt;
    logic              d_gnt;
    logic              f_legal;
    logic              d_legal;
    logic              acc_f;
    logic              acc_d;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              f_rvalid_q;
    logic              f_err_q;
    logic [31:0]       f_rdata_q;
    logic              d_rvalid_q;
    logic              d_err_q;
    logic [31:0]       d_rdata_q;

    // Word aligned and inside the memory window.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
    endfunction

    assign force_dbg = (starve == STARVE_MAX);

    always_comb begin
        state_nxt  = state;
        starve_nxt = '0;
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        case (state)
            RUN: begin
                if (bus.halt) begin
                    state_nxt = HALTED;
                end
                if (bus.f_req && !(bus.d_req && force_dbg)) begin
                    f_gnt = 1'b1;
                end else if (bus.d_req) begin
                    d_gnt = 1'b1;
                end
                if (bus.d_req && !d_gnt) begin
                    starve_nxt = force_dbg ? starve : starve + CNT_W'(1);
                end
            end
            HALTED: begin
                if (!bus.halt) begin
                    state_nxt = RUN;
                end
                d_gnt = bus.d_req;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        // Grants must vanish the moment reset asserts, without waiting for a clock.
        if (!rst_n) begin
            f_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    assign f_legal = addr_legal(bus.f_addr);
    assign d_legal = addr_legal(bus.d_addr);
    assign acc_f   = f_gnt && f_legal;
    assign acc_d   = d_gnt && d_legal;

    always_comb begin
        mem_addr = mem_addr_q;
        if (acc_f) begin
            mem_addr = bus.f_addr[ADDR_W+1:2];
        end else if (acc_d) begin
            mem_addr = bus.d_addr[ADDR_W+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            starve     <= '0;
            mem_addr_q <= '0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            mem_addr_q <= mem_addr;
            f_rvalid_q <= f_gnt;
            f_err_q    <= f_gnt && !f_legal;
            f_rdata_q  <= acc_f ? bus.mem_rdata : 32'd0;
            d_rvalid_q <= d_gnt;
            d_err_q    <= d_gnt && !d_legal;
            d_rdata_q  <= (acc_d && !bus.d_we) ? bus.mem_rdata : 32'd0;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.f_err     = f_err_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.halted    = (state == HALTED);
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = acc_d && bus.d_we;
    assign bus.mem_wdata = bus.d_wdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and random checks of imem_arbiter against a cycle-level reference
// model built from the arbitration, legality and response rules.
module tb_imem_arbiter;
    localparam int ADDR_W   = 12;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: combinational read, write captured mid-cycle and applied on the edge.
    assign bus.mem_rdata = mem[bus.mem_addr];
    initial begin
        logic              wr_en;
        logic [ADDR_W-1:0] wr_a;
        logic [31:0]       wr_d;
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        mem[2] = 32'h0050_0093;
        forever begin
            @(negedge clk);
            wr_en = (bus.mem_we === 1'b1);
            wr_a  = bus.mem_addr;
            wr_d  = bus.mem_wdata;
            @(posedge clk);
            if (wr_en) mem[wr_a] <= wr_d;
        end
    end

    // Reference model state
    logic              m_halted;
    int                m_wait;
    logic [ADDR_W-1:0] m_addr;
    logic              m_f_rv, m_f_err, m_d_rv, m_d_err;
    logic [31:0]       m_f_rd, m_d_rd;
    logic              g_f_gnt, g_d_gnt;

    logic              obs_f_gnt, obs_d_gnt, obs_we;
    logic              obs_f_rv, obs_f_err, obs_d_rv, obs_d_err;
    logic [31:0]       obs_f_rd, obs_d_rd;

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a / 4) % DEPTH;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r = int'($urandom % 10);
        logic [31:0] a = 32'($urandom % 16) * 4;
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = a | (32'h1 << (14 + $urandom % 18));
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_wait   = 0;
        m_addr   = '0;
        m_f_rv   = 1'b0; m_f_err = 1'b0; m_f_rd = '0;
        m_d_rv   = 1'b0; m_d_err = 1'b0; m_d_rd = '0;
        g_f_gnt  = 1'b0; g_d_gnt = 1'b0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        logic              fl, dl, e_f, e_d, acc_f, acc_d, ewe;
        logic [ADDR_W-1:0] ea;
        logic              nf_rv, nf_err, nd_rv, nd_err;
        logic [31:0]       nf_rd, nd_rd;
        #4;
        fl = legal(bus.f_addr);
        dl = legal(bus.d_addr);
        if (m_halted) begin
            e_f = 1'b0;
            e_d = bus.d_req;
        end else if (bus.f_req && !(bus.d_req && m_wait == MAX_WAIT)) begin
            e_f = 1'b1;
            e_d = 1'b0;
        end else begin
            e_f = 1'b0;
            e_d = bus.d_req;
        end
        acc_f = e_f && fl;
        acc_d = e_d && dl;
        ea    = acc_f ? ADDR_W'(widx(bus.f_addr)) : acc_d ? ADDR_W'(widx(bus.d_addr)) : m_addr;
        ewe   = acc_d && bus.d_we;

        obs_f_gnt = bus.f_gnt;  obs_d_gnt = bus.d_gnt;  obs_we = bus.mem_we;
        obs_f_rv  = bus.f_rvalid; obs_f_err = bus.f_err; obs_f_rd = bus.f_rdata;
        obs_d_rv  = bus.d_rvalid; obs_d_err = bus.d_err; obs_d_rd = bus.d_rdata;

        chk("f_gnt",    32'(bus.f_gnt),    32'(e_f));
        chk("d_gnt",    32'(bus.d_gnt),    32'(e_d));
        chk("mem_we",   32'(bus.mem_we),   32'(ewe));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("halted",   32'(bus.halted),   32'(m_halted));
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(m_f_rv));
        chk("f_err",    32'(bus.f_err),    32'(m_f_err));
        chk("f_rdata",  bus.f_rdata,       m_f_rd);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_d_rv));
        chk("d_err",    32'(bus.d_err),    32'(m_d_err));
        chk("d_rdata",  bus.d_rdata,       m_d_rd);
        if (ewe) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);

        nf_rv  = e_f;
        nf_err = e_f && !fl;
        nf_rd  = acc_f ? shadow[widx(bus.f_addr)] : 32'd0;
        nd_rv  = e_d;
        nd_err = e_d && !dl;
        nd_rd  = (acc_d && !bus.d_we) ? shadow[widx(bus.d_addr)] : 32'd0;
        if (ewe) shadow[widx(bus.d_addr)] = bus.d_wdata;

        if (m_halted || !bus.d_req || e_d) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        m_halted = bus.halt;
        m_addr   = ea;
        g_f_gnt  = e_f;
        g_d_gnt  = e_d;

        @(posedge clk);
        m_f_rv = nf_rv; m_f_err = nf_err; m_f_rd = nf_rd;
        m_d_rv = nd_rv; m_d_err = nd_err; m_d_rd = nd_rd;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_f_gnt"},    32'(bus.f_gnt),    32'd0);
        chk({tag, "_d_gnt"},    32'(bus.d_gnt),    32'd0);
        chk({tag, "_f_rvalid"}, 32'(bus.f_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
        chk({tag, "_f_err"},    32'(bus.f_err),    32'd0);
        chk({tag, "_d_err"},    32'(bus.d_err),    32'd0);
        chk({tag, "_f_rdata"},  bus.f_rdata,       32'd0);
        chk({tag, "_d_rdata"},  bus.d_rdata,       32'd0);
        chk({tag, "_halted"},   32'(bus.halted),   32'd0);
        chk({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        shadow[2] = 32'h0050_0093;

        // Reset applied before any clock edge, with requests pending.
        rst_n = 1'b0;
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h1234_5678;
        bus.halt = 1'b0;
        #2;
        chk_reset_outputs("rst0");
        @(posedge clk); @(posedge clk); #1;
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // First fetch right after reset release.
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        cycle();
        chk("t037_gnt", 32'(obs_f_gnt), 32'd1);
        bus.f_req = 1'b0;
        cycle();
        chk("t037_rvalid", 32'(obs_f_rv), 32'd1);
        chk("t037_rdata",  obs_f_rd,      32'h0050_0093);
        chk("t037_err",    32'(obs_f_err), 32'd0);

        // Continuous contention: four fetches then one debug, repeating.
        bus.f_req = 1'b1; bus.f_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        for (int k = 0; k < 15; k++) begin
            cycle();
            chk("t038_dgnt", 32'(obs_d_gnt), 32'((k % 5) == 4));
            chk("t038_fgnt", 32'(obs_f_gnt), 32'((k % 5) != 4));
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        cycle();

        // Illegal accesses: misaligned debug read, out-of-range fetch.
        bus.f_req = 1'b1; bus.f_addr = 32'h4000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6;
        cycle();
        chk("t040_we0", 32'(obs_we), 32'd0);
        bus.f_req = 1'b0;
        cycle();
        chk("t040_we1",   32'(obs_we),    32'd0);
        chk("t040_f_err", 32'(obs_f_err), 32'd1);
        chk("t040_f_rd",  obs_f_rd,       32'd0);
        bus.d_req = 1'b0;
        cycle();
        chk("t040_d_err", 32'(obs_d_err), 32'd1);
        chk("t040_d_rd",  obs_d_rd,       32'd0);

        // Halted: debug write then read-back, fetch held off.
        bus.halt = 1'b1;
        cycle();
        bus.f_req = 1'b1; bus.f_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("t039_halted0", 32'(bus.halted), 32'd1);
        chk("t039_fgnt0",   32'(obs_f_gnt),  32'd0);
        bus.d_we = 1'b0;
        cycle();
        chk("t039_fgnt1",   32'(obs_f_gnt),  32'd0);
        chk("t039_wr_ack",  32'(obs_d_rv),   32'd1);
        bus.d_req = 1'b0;
        cycle();
        chk("t039_fgnt2",   32'(obs_f_gnt),  32'd0);
        chk("t039_rd_v",    32'(obs_d_rv),   32'd1);
        chk("t039_rdata",   obs_d_rd,        32'hDEAD_BEEF);
        chk("t039_err",     32'(obs_d_err),  32'd0);
        bus.halt = 1'b0;
        cycle();
        cycle();
        bus.f_req = 1'b0;
        cycle();

        // Random traffic; each requester holds its request until granted.
        for (int n = 0; n < 400; n++) begin
            if (!bus.f_req || g_f_gnt) begin
                bus.f_req  = ($urandom % 3) != 0;
                bus.f_addr = rand_addr();
            end
            if (!bus.d_req || g_d_gnt) begin
                bus.d_req   = ($urandom % 2) != 0;
                bus.d_we    = ($urandom % 2) != 0;
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom;
            end
            if ($urandom % 20 == 0) bus.halt = ~bus.halt;
            cycle();
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.halt = 1'b0;
        cycle();
        cycle();

        // Reset during the response cycle of a fetch.
        bus.f_req = 1'b1; bus.f_addr = 32'hC;
        cycle();
        chk("t041_gnt", 32'(obs_f_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t041");
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle();
        chk("t041_no_rv", 32'(obs_f_rv), 32'd0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the instruction memory (4096 words).
REQ-002 Parameter MAX_WAIT, default 4, consecutive cycles debug may be refused while requesting before it is forced to win.
REQ-003 One clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 f_req_i  in  1  fetch read request.
REQ-007 f_addr_i  in  32  fetch byte address.
REQ-008 f_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 f_rvalid_o  out  1  fetch response valid.
REQ-010 f_rdata_o  out  32  fetch instruction word.
REQ-011 f_err_o  out  1  fetch response is an error (valid with f_rvalid_o).
REQ-012 d_req_i  in  1  debug/loader request.
REQ-013 d_we_i  in  1  debug request is a write.
REQ-014 d_addr_i  in  32  debug byte address.
REQ-015 d_wdata_i  in  32  debug write data.
REQ-016 d_gnt_o, d_rvalid_o, d_err_o  out  1 each  debug accept, response valid, response error.
REQ-017 d_rdata_o  out  32  debug read data.
REQ-018 halt_i  in  1  level request to block fetch.
REQ-019 halted_o  out  1  fetch is blocked.
REQ-020 mem_addr_o  out  ADDR_W  memory word address; mem_we_o  out  1  write strobe; mem_wdata_o  out  32  write data; mem_rdata_i  in  32  combinational read data.

Function
REQ-021 At most one grant per cycle; gnt is combinational from req, state and starve counter.
REQ-022 Priority in RUN: fetch wins over debug unless starve counter == MAX_WAIT, then debug wins.
REQ-023 Starve counter: +1 (saturating at MAX_WAIT) each cycle d_req_i high and d_gnt_o low; cleared when d_gnt_o high or d_req_i low.
REQ-024 Requester holds req and address/data stable until gnt; no gnt without req.
REQ-025 Granted access drives mem_addr_o = addr[ADDR_W+1:2] same cycle; mem_we_o = 1 only for a legal debug write; otherwise mem_addr_o holds last value, mem_we_o 0.
REQ-026 Illegal access: addr[1:0] != 0 or addr[31:ADDR_W+2] != 0; still granted, no memory access, mem_we_o 0.
REQ-027 Response exactly 1 cycle after gnt: rvalid pulses 1 cycle; rdata registered from mem_rdata_i for legal reads, 0 for writes and errors; err = 1 only for illegal.
REQ-028 Debug writes return a response (ack) with rdata 0, err 0 when legal.
REQ-029 Back-to-back grants to the same port give back-to-back responses, in order.
REQ-030 FSM states RUN, HALTED; RUN -> HALTED when halt_i sampled 1; HALTED -> RUN when halt_i sampled 0.
REQ-031 In HALTED: f_gnt_o = 0, debug granted whenever d_req_i, starve counter held 0; halted_o = 1 iff state HALTED.
REQ-032 Fetch granted in the cycle halt_i rises still completes its response next cycle.
REQ-033 Debug write and debug read to same address in consecutive grants: read returns the written data.

Reset
REQ-034 On rst_ni low: state RUN, starve counter 0, all gnt/rvalid/err 0, rdata 0, halted_o 0, mem_we_o 0, mem_addr_o 0; effective immediately, no clock required.
REQ-035 Reset asserted mid-transaction drops the pending response; no rvalid after reset release without a new grant.
REQ-036 First grant possible on the first rising edge after rst_ni deasserts.

Verification
REQ-037 f_req_i=1 addr 0x8, mem[2]=0x00500093 -> f_gnt_o same cycle, next cycle f_rvalid_o=1, f_rdata_o=0x00500093, f_err_o=0.
REQ-038 f_req_i and d_req_i held 1 continuously, MAX_WAIT=4 -> fetch granted 4 cycles, debug granted 5th cycle, counter cleared, pattern repeats.
REQ-039 halt_i=1, d write 0xDEADBEEF to 0x10 then read 0x10 -> halted_o=1, f_gnt_o=0 throughout, read response 0xDEADBEEF, d_err_o=0.
REQ-040 d read addr 0x6 and fetch addr 0x4000 -> both granted, mem_we_o=0, responses err=1, rdata=0.
REQ-041 rst_ni pulled low the cycle after a fetch grant -> no f_rvalid_o, all outputs at reset values asynchronously.
